// File: rtl/icache_pkg.sv
// Shared constants for the direct-mapped instruction cache.
// State encoding and default geometry live here so the bench and RTL agree.
package icache_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int INDEX_WIDTH_DEF = 8;

    typedef enum logic {
        STATE_IDLE = 1'b0,
        STATE_MISS = 1'b1
    } state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with a combinational hit path
// and a single outstanding miss toward the memory controller's fetch port.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_WIDTH = INDEX_WIDTH_DEF,
    parameter int TAG_WIDTH   = 30 - INDEX_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    output logic        hit,
    output logic [31:0] inst,
    output logic        mem_valid,
    output logic [31:0] mem_ain,
    input  logic        mem_enable,
    input  logic [31:0] mem_din
);

    // state | meaning
    // IDLE  | serve lookups; a miss latches its word address and moves to MISS
    // MISS  | request outstanding; wait for mem_enable (fill) or clear (abandon)

    localparam int LINES = 1 << INDEX_WIDTH;

    state_t                 state;
    logic [29:0]            miss_word;
    logic [LINES-1:0]       line_valid;
    logic [TAG_WIDTH-1:0]   tag_arr  [LINES];
    logic [31:0]            data_arr [LINES];

    logic [INDEX_WIDTH-1:0] pc_index;
    logic [INDEX_WIDTH-1:0] miss_index;
    logic [TAG_WIDTH-1:0]   pc_tag;
    logic [TAG_WIDTH-1:0]   miss_tag;
    logic                   lookup_hit;
    logic                   bypass_hit;
    logic                   fill;
    logic                   active;
    logic                   unused_pc_bits;

    assign unused_pc_bits = ^if_pc[1:0];

    assign pc_index   = if_pc[INDEX_WIDTH+1:2];
    assign pc_tag     = if_pc[31:INDEX_WIDTH+2];
    assign miss_index = miss_word[INDEX_WIDTH-1:0];
    assign miss_tag   = miss_word[29:INDEX_WIDTH];

    assign active     = rdy && !rst;
    assign lookup_hit = line_valid[pc_index] && (tag_arr[pc_index] == pc_tag);
    assign bypass_hit = (state == STATE_MISS) && mem_enable && (if_pc[31:2] == miss_word);
    assign fill       = active && (state == STATE_MISS) && mem_enable;

    // Lookup sees pre-fill contents; only the returning word itself is forwarded.
    always_comb begin
        hit  = FALSE;
        inst = '0;
        if (active && if_valid && !clear) begin
            if ((state == STATE_IDLE) && lookup_hit) begin
                hit  = TRUE;
                inst = data_arr[pc_index];
            end else if (bypass_hit) begin
                hit  = TRUE;
                inst = mem_din;
            end
        end
    end

    // Drop valid in the enable cycle so the controller does not relaunch the fetch.
    assign mem_valid = !rst && (state == STATE_MISS) && !(rdy && (mem_enable || clear));
    assign mem_ain   = {miss_word, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= STATE_IDLE;
            miss_word  <= '0;
            line_valid <= '0;
        end else if (rdy) begin
            case (state)
                STATE_IDLE: begin
                    if (if_valid && !lookup_hit && !clear) begin
                        state     <= STATE_MISS;
                        miss_word <= if_pc[31:2];
                    end
                end
                STATE_MISS: begin
                    if (mem_enable) begin
                        line_valid[miss_index] <= TRUE;
                        state                  <= STATE_IDLE;
                    end else if (clear) begin
                        state <= STATE_IDLE;
                    end
                end
                default: state <= STATE_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_arr[miss_index]  <= miss_tag;
            data_arr[miss_index] <= mem_din;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed cycle table plus randomized traffic
// against a line-array reference model.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst, rdy, clear, if_valid, mem_enable;
    logic [31:0] if_pc, mem_din;
    logic        hit, mem_valid;
    logic [31:0] inst, mem_ain;

    int total = 0;
    int bad   = 0;

    icache dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .if_valid(if_valid),
        .if_pc(if_pc), .hit(hit), .inst(inst), .mem_valid(mem_valid),
        .mem_ain(mem_ain), .mem_enable(mem_enable), .mem_din(mem_din)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          clr;
        bit          v;
        logic [31:0] pc;
        bit          en;
        logic [31:0] din;
        bit          eh;
        logic [31:0] ei;
        bit          emv;
        logic [31:0] ea;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit r, bit ry, bit c, bit v, logic [31:0] pc, bit en,
                                logic [31:0] din, bit eh, logic [31:0] ei, bit emv,
                                logic [31:0] ea);
        vec_t x;
        x.rst = r; x.rdy = ry; x.clr = c; x.v = v; x.pc = pc; x.en = en; x.din = din;
        x.eh = eh; x.ei = ei; x.emv = emv; x.ea = ea;
        tbl.push_back(x);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(bit r, bit ry, bit c, bit v, logic [31:0] pc, bit en, logic [31:0] din);
        rst = r; rdy = ry; clear = c; if_valid = v; if_pc = pc; mem_enable = en; mem_din = din;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        drive(1, 1, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    // Reference model: the cache as arrays of lines indexed by word address.
    bit          m_valid [256];
    logic [31:0] m_tag   [256];
    logic [31:0] m_data  [256];
    bit          m_pend;
    logic [31:0] m_addr;

    function automatic int idx_of(logic [31:0] a);
        return int'((a >> 2) % 256);
    endfunction

    function automatic void model_reset();
        foreach (m_valid[i]) m_valid[i] = 0;
        m_pend = 0;
        m_addr = 0;
    endfunction

    function automatic bit model_present(logic [31:0] a);
        return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == (a >> 10));
    endfunction

    initial begin
        drive(1, 1, 0, 0, 0, 0, 0);

        // reset state
        add(0,1,0,0,32'h0,0,0, 0,0,0,32'h0);
        // cold miss, answered 6 cycles after the request
        add(0,1,0,1,32'h1000,0,0, 0,0,0,32'h0);
        repeat (5) add(0,1,0,1,32'h1000,0,0, 0,0,1,32'h1000);
        add(0,1,0,1,32'h1000,1,32'h00500093, 1,32'h00500093,0,32'h1000);
        // warm hit
        add(0,1,0,1,32'h1000,0,0, 1,32'h00500093,0,32'h1000);
        // conflict on index 0
        add(0,1,0,1,32'h1400,0,0, 0,0,0,32'h1000);
        add(0,1,0,1,32'h1400,0,0, 0,0,1,32'h1400);
        add(0,1,0,1,32'h1400,1,32'hAAAA0001, 1,32'hAAAA0001,0,32'h1400);
        add(0,1,0,1,32'h1000,0,0, 0,0,0,32'h1400);
        add(0,1,0,1,32'h1000,0,0, 0,0,1,32'h1000);
        add(0,1,0,1,32'h1000,1,32'h00500093, 1,32'h00500093,0,32'h1000);
        // flush mid-miss, then the same address misses again
        add(0,1,0,1,32'h2000,0,0, 0,0,0,32'h1000);
        add(0,1,0,1,32'h2000,0,0, 0,0,1,32'h2000);
        add(0,1,0,1,32'h2000,0,0, 0,0,1,32'h2000);
        add(0,1,1,1,32'h2000,0,0, 0,0,0,32'h2000);
        add(0,1,0,0,32'h2000,0,0, 0,0,0,32'h2000);
        add(0,1,0,1,32'h2000,0,0, 0,0,0,32'h2000);
        add(0,1,0,1,32'h2000,0,0, 0,0,1,32'h2000);
        add(0,1,0,1,32'h2000,1,32'h22220000, 1,32'h22220000,0,32'h2000);
        // clear coincident with enable still installs
        add(0,1,0,1,32'h3000,0,0, 0,0,0,32'h2000);
        add(0,1,0,1,32'h3000,0,0, 0,0,1,32'h3000);
        add(0,1,1,1,32'h3000,1,32'h33330000, 0,0,0,32'h3000);
        add(0,1,0,1,32'h3000,0,0, 1,32'h33330000,0,32'h3000);
        add(0,1,1,1,32'h3000,0,0, 0,0,0,32'h3000);
        // rdy low during MISS
        add(0,1,0,1,32'h4000,0,0, 0,0,0,32'h3000);
        add(0,1,0,1,32'h4000,0,0, 0,0,1,32'h4000);
        repeat (5) add(0,0,0,1,32'h4000,0,0, 0,0,1,32'h4000);
        add(0,1,0,1,32'h4000,0,0, 0,0,1,32'h4000);
        add(0,1,0,1,32'h4000,1,32'h44440000, 1,32'h44440000,0,32'h4000);
        add(0,0,0,1,32'h4000,0,0, 0,0,0,32'h4000);
        // spurious enable in IDLE must not write
        add(0,1,0,0,32'h0,1,32'hDEADBEEF, 0,0,0,32'h4000);
        add(0,1,0,1,32'h4000,0,0, 1,32'h44440000,0,32'h4000);
        // pc changed during MISS: fill installs, no hit; low pc bits ignored
        add(0,1,0,1,32'h6000,0,0, 0,0,0,32'h4000);
        add(0,1,0,1,32'h6000,0,0, 0,0,1,32'h6000);
        add(0,1,0,1,32'h1000,1,32'h66660000, 0,0,0,32'h6000);
        add(0,1,0,1,32'h6003,0,0, 1,32'h66660000,0,32'h6000);
        add(0,1,0,1,32'h1000,0,0, 0,0,0,32'h6000);
        add(0,1,1,1,32'h1000,0,0, 0,0,0,32'h1000);
        // a second index
        add(0,1,0,1,32'h1004,0,0, 0,0,0,32'h1000);
        add(0,1,0,1,32'h1004,0,0, 0,0,1,32'h1004);
        add(0,1,0,1,32'h1004,1,32'h11110004, 1,32'h11110004,0,32'h1004);
        add(0,1,0,1,32'h6000,0,0, 1,32'h66660000,0,32'h1004);
        add(0,1,0,1,32'h1004,0,0, 1,32'h11110004,0,32'h1004);
        // reset mid-miss clears state and valid bits
        add(0,1,0,1,32'h7000,0,0, 0,0,0,32'h1004);
        add(0,1,0,1,32'h7000,0,0, 0,0,1,32'h7000);
        add(1,1,0,1,32'h7000,0,0, 0,0,0,32'h7000);
        add(0,1,0,0,32'h0,0,0, 0,0,0,32'h0);
        add(0,1,0,1,32'h6000,0,0, 0,0,0,32'h0);
        add(0,1,1,1,32'h6000,0,0, 0,0,0,32'h6000);

        do_reset();
        #3;
        check("reset_inst", inst, 32'h0);
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            drive(tbl[i].rst, tbl[i].rdy, tbl[i].clr, tbl[i].v, tbl[i].pc, tbl[i].en, tbl[i].din);
            #3;
            check($sformatf("row%0d_hit", i), {31'b0, hit}, {31'b0, tbl[i].eh});
            if (tbl[i].eh) check($sformatf("row%0d_inst", i), inst, tbl[i].ei);
            check($sformatf("row%0d_mem_valid", i), {31'b0, mem_valid}, {31'b0, tbl[i].emv});
            check($sformatf("row%0d_mem_ain", i), mem_ain, tbl[i].ea);
        end

        // randomized traffic against the reference model
        do_reset();
        model_reset();
        begin
            bit          r_rdy, r_clr, r_v, r_en, e_hit, e_mv;
            logic [31:0] r_pc, r_din, e_inst;
            int          lat;
            r_pc = 0; r_v = 0; lat = 3;
            for (int n = 0; n < 3000; n++) begin
                r_rdy = ($urandom_range(0, 9) != 0);
                r_clr = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 9) < 3) begin
                    r_v  = ($urandom_range(0, 4) != 0);
                    r_pc = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 2)
                           | 32'($urandom_range(0, 3));
                end
                r_din = $urandom;
                r_en  = m_pend ? (lat == 0) : ($urandom_range(0, 29) == 0);

                if (!r_rdy || r_clr || !r_v) e_hit = 0;
                else if (!m_pend)             e_hit = model_present(r_pc);
                else                          e_hit = r_en && ((r_pc >> 2) == (m_addr >> 2));
                e_inst = m_pend ? r_din : m_data[idx_of(r_pc)];
                e_mv   = m_pend && !(r_rdy && (r_en || r_clr));

                @(posedge clk); #1;
                drive(0, r_rdy, r_clr, r_v, r_pc, r_en, r_din);
                #3;
                check($sformatf("rnd%0d_hit", n), {31'b0, hit}, {31'b0, e_hit});
                if (e_hit) check($sformatf("rnd%0d_inst", n), inst, e_inst);
                check($sformatf("rnd%0d_mem_valid", n), {31'b0, mem_valid}, {31'b0, e_mv});
                check($sformatf("rnd%0d_mem_ain", n), mem_ain, m_addr);

                if (r_rdy) begin
                    if (!m_pend) begin
                        if (r_v && !r_clr && !model_present(r_pc)) begin
                            m_pend = 1;
                            m_addr = r_pc & ~32'h3;
                            lat    = $urandom_range(0, 5);
                        end
                    end else if (r_en) begin
                        m_valid[idx_of(m_addr)] = 1;
                        m_tag[idx_of(m_addr)]   = m_addr >> 10;
                        m_data[idx_of(m_addr)]  = r_din;
                        m_pend = 0;
                    end else if (r_clr) begin
                        m_pend = 0;
                    end else if (lat > 0) begin
                        lat--;
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
